// File: rtl/uart_text_pkg.sv
// Shared definitions for the UART text terminal controller: FSM encoding,
// cursor commands, character constants and the printable-range helper.
package uart_text_pkg;

  localparam int XW = 7;
  localparam int YW = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ECHO,
    ST_CLEAR
  } state_t;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_ADV,
    CUR_NL,
    CUR_BACK,
    CUR_HOME
  } cur_cmd_t;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_PR_LO = 8'h20;
  localparam logic [7:0] CH_PR_HI = 8'h7E;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CH_PR_LO) && (c <= CH_PR_HI);
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Text cursor register with single-cycle advance/newline/backstep/home commands.
// Also exposes the backstep target so the caller can write the erased cell.
module text_cursor
  import uart_text_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  input  cur_cmd_t      i_cmd,
  output logic [XW-1:0] o_cur_x,
  output logic [YW-1:0] o_cur_y,
  output logic [XW-1:0] o_back_x,
  output logic [YW-1:0] o_back_y,
  output logic          o_at_home
);

  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

  logic [YW-1:0] w_row_inc;
  logic [XW-1:0] w_nx;
  logic [YW-1:0] w_ny;

  // No scrolling: the last row wraps back to the top.
  assign w_row_inc = (o_cur_y == Y_MAX) ? '0 : o_cur_y + YW'(1);
  assign o_at_home = (o_cur_x == '0) && (o_cur_y == '0);
  assign o_back_x  = (o_cur_x == '0) ? X_MAX : o_cur_x - XW'(1);
  assign o_back_y  = (o_cur_x != '0) ? o_cur_y :
                     (o_cur_y == '0) ? Y_MAX : o_cur_y - YW'(1);

  always_comb begin
    w_nx = o_cur_x;
    w_ny = o_cur_y;
    case (i_cmd)
      CUR_ADV: begin
        if (o_cur_x == X_MAX) begin
          w_nx = '0;
          w_ny = w_row_inc;
        end else begin
          w_nx = o_cur_x + XW'(1);
        end
      end
      CUR_NL: begin
        w_nx = '0;
        w_ny = w_row_inc;
      end
      CUR_BACK: begin
        if (!o_at_home) begin
          w_nx = o_back_x;
          w_ny = o_back_y;
        end
      end
      CUR_HOME: begin
        w_nx = '0;
        w_ny = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cur_x <= '0;
      o_cur_y <= '0;
    end else begin
      o_cur_x <= w_nx;
      o_cur_y <= w_ny;
    end
  end

endmodule

// File: rtl/uart_text_ctrl.sv
// UART-to-text-buffer controller: pops one received byte at a time, renders it
// into VRAM with cursor handling, optionally echoes it, and clears on ESC.
module uart_text_ctrl
  import uart_text_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int ECHO = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_empty,
  input  logic [7:0]    rd_data,
  input  logic          tx_full,
  output logic          rd_uart,
  output logic          wr_uart,
  output logic [7:0]    wr_data,
  output logic          vram_we,
  output logic [XW-1:0] vram_x,
  output logic [YW-1:0] vram_y,
  output logic [7:0]    vram_din,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y
);

  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

  state_t        r_state, w_state;
  logic [7:0]    r_char, w_char;
  logic [XW-1:0] r_clr_x, w_clr_x;
  logic [YW-1:0] r_clr_y, w_clr_y;

  logic          w_rd, w_wr, w_we;
  logic [7:0]    w_wdata, w_vdin;
  logic [XW-1:0] w_vx;
  logic [YW-1:0] w_vy;
  cur_cmd_t      w_cmd;

  logic [XW-1:0] w_back_x;
  logic [YW-1:0] w_back_y;
  logic          w_at_home;

  text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_cmd    (w_cmd),
    .o_cur_x  (cur_x),
    .o_cur_y  (cur_y),
    .o_back_x (w_back_x),
    .o_back_y (w_back_y),
    .o_at_home(w_at_home)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state = r_state;
    w_char  = r_char;
    w_clr_x = r_clr_x;
    w_clr_y = r_clr_y;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_we    = 1'b0;
    w_wdata = wr_data;
    w_vx    = vram_x;
    w_vy    = vram_y;
    w_vdin  = vram_din;
    w_cmd   = CUR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (!rx_empty) begin
          w_char  = rd_data;
          w_rd    = 1'b1;
          w_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_state = (ECHO != 0) ? ST_ECHO : ST_IDLE;
        if (is_printable(r_char)) begin
          w_we   = 1'b1;
          w_vx   = cur_x;
          w_vy   = cur_y;
          w_vdin = r_char;
          w_cmd  = CUR_ADV;
        end else if (r_char == CH_CR) begin
          w_cmd = CUR_NL;
        end else if (r_char == CH_BS) begin
          // Backspace at home still echoes but has nothing to erase.
          if (!w_at_home) begin
            w_we   = 1'b1;
            w_vx   = w_back_x;
            w_vy   = w_back_y;
            w_vdin = CH_SP;
            w_cmd  = CUR_BACK;
          end
        end else if (r_char == CH_ESC) begin
          w_state = ST_CLEAR;
          w_clr_x = '0;
          w_clr_y = '0;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_ECHO: begin
        if (!tx_full) begin
          w_wr    = 1'b1;
          w_wdata = r_char;
          w_state = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        w_we   = 1'b1;
        w_vx   = r_clr_x;
        w_vy   = r_clr_y;
        w_vdin = CH_SP;
        if (r_clr_x == X_MAX) begin
          w_clr_x = '0;
          if (r_clr_y == Y_MAX) begin
            w_state = ST_IDLE;
            w_cmd   = CUR_HOME;
          end else begin
            w_clr_y = r_clr_y + YW'(1);
          end
        end else begin
          w_clr_x = r_clr_x + XW'(1);
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_char   <= 8'h00;
      r_clr_x  <= '0;
      r_clr_y  <= '0;
      rd_uart  <= 1'b0;
      wr_uart  <= 1'b0;
      vram_we  <= 1'b0;
      wr_data  <= 8'h00;
      vram_x   <= '0;
      vram_y   <= '0;
      vram_din <= 8'h00;
    end else begin
      r_state  <= w_state;
      r_char   <= w_char;
      r_clr_x  <= w_clr_x;
      r_clr_y  <= w_clr_y;
      rd_uart  <= w_rd;
      wr_uart  <= w_wr;
      vram_we  <= w_we;
      wr_data  <= w_wdata;
      vram_x   <= w_vx;
      vram_y   <= w_vy;
      vram_din <= w_vdin;
    end
  end

endmodule

// File: tb/tb_uart_text_ctrl.sv
// Scoreboard bench for uart_text_ctrl: stimulus pushes expected VRAM writes and
// echoes; a negedge monitor pops and compares whenever the DUT strobes.
module tb_uart_text_ctrl;

  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_empty;
  logic [7:0] rd_data;
  logic       tx_full = 1'b0;
  logic       rd_uart, wr_uart, vram_we;
  logic [7:0] wr_data, vram_din;
  logic [6:0] vram_x, cur_x;
  logic [4:0] vram_y, cur_y;

  uart_text_ctrl #(.COLS(COLS), .ROWS(ROWS), .ECHO(1)) dut (
    .clk(clk), .rst_n(rst_n), .rx_empty(rx_empty), .rd_data(rd_data),
    .tx_full(tx_full), .rd_uart(rd_uart), .wr_uart(wr_uart), .wr_data(wr_data),
    .vram_we(vram_we), .vram_x(vram_x), .vram_y(vram_y), .vram_din(vram_din),
    .cur_x(cur_x), .cur_y(cur_y)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // receive FIFO model: main writes rx_wp, monitor advances rx_rp
  logic [7:0]  rx_mem [0:4095];
  int          rx_wp = 0, rx_rp = 0;
  assign rx_empty = (rx_wp == rx_rp);
  assign rd_data  = rx_mem[rx_rp[11:0]];

  logic [19:0] exp_w [0:8191];
  int          w_wp = 0, w_rp = 0;
  logic [7:0]  exp_e [0:8191];
  int          e_wp = 0, e_rp = 0;

  int rd_cyc = -100, we_cyc = 0, wr_cyc = 0;
  int min_rd_gap = 1000;
  int we_run = 0, max_run = 0;

  logic [6:0] mx = '0;
  logic [4:0] my = '0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_uart || wr_uart || vram_we)
        chk("strobe_excl", int'(rd_uart) + int'(wr_uart) + int'(vram_we), 1);
      if (rd_uart) begin
        if (cyc - rd_cyc < min_rd_gap) min_rd_gap = cyc - rd_cyc;
        rd_cyc = cyc;
        if (rx_rp != rx_wp) rx_rp = rx_rp + 1;
      end
      if (vram_we) begin
        we_cyc = cyc;
        we_run = we_run + 1;
        if (we_run > max_run) max_run = we_run;
        if (w_rp == w_wp) begin
          n_cmp++; n_err++;
          $display("FAIL write_unexpected: got (%0d,%0d,0x%0h) expected none",
                   vram_x, vram_y, vram_din);
        end else begin
          chk("vram_write", int'({vram_x, vram_y, vram_din}), int'(exp_w[w_rp[12:0]]));
          w_rp = w_rp + 1;
        end
      end else begin
        we_run = 0;
      end
      if (wr_uart) begin
        wr_cyc = cyc;
        if (e_rp == e_wp) begin
          n_cmp++; n_err++;
          $display("FAIL echo_unexpected: got 0x%0h expected none", wr_data);
        end else begin
          chk("echo", int'(wr_data), int'(exp_e[e_rp[12:0]]));
          e_rp = e_rp + 1;
        end
      end
    end
  end

  task automatic push_w(input logic [6:0] x, input logic [4:0] y, input logic [7:0] d);
    exp_w[w_wp[12:0]] = {x, y, d};
    w_wp = w_wp + 1;
  endtask

  task automatic push_e(input logic [7:0] d);
    exp_e[e_wp[12:0]] = d;
    e_wp = e_wp + 1;
  endtask

  task automatic row_inc();
    my = (my == 5'(ROWS - 1)) ? 5'd0 : my + 5'd1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_mem[rx_wp[11:0]] = b;
    rx_wp = rx_wp + 1;
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_w(mx, my, b);
      if (mx == 7'(COLS - 1)) begin mx = '0; row_inc(); end
      else mx = mx + 7'd1;
      push_e(b);
    end else if (b == 8'h0D) begin
      mx = '0; row_inc(); push_e(b);
    end else if (b == 8'h08) begin
      if (!(mx == 0 && my == 0)) begin
        if (mx == 0) begin mx = 7'(COLS - 1); my = my - 5'd1; end
        else mx = mx - 7'd1;
        push_w(mx, my, 8'h20);
      end
      push_e(b);
    end else if (b == 8'h1B) begin
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < COLS; x++) push_w(7'(x), 5'(y), 8'h20);
      mx = '0; my = '0;
    end
  endtask

  task automatic flush();
    rx_wp = rx_rp; w_wp = w_rp; e_wp = e_rp;
    mx = '0; my = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((rx_rp != rx_wp || w_rp != w_wp || e_rp != e_wp) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d cycles expected < %0d", n, budget);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_cur(input string nm, input int x, input int y);
    chk({nm, "_x"}, int'(cur_x), x);
    chk({nm, "_y"}, int'(cur_y), y);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_strobes"}, int'({rd_uart, wr_uart, vram_we}), 0);
    chk({nm, "_wr_data"}, int'(wr_data), 0);
    chk({nm, "_vram_addr"}, int'({vram_x, vram_y}), 0);
    chk({nm, "_vram_din"}, int'(vram_din), 0);
    chk_cur(nm, 0, 0);
  endtask

  initial begin
    int n, stall;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // single printable byte: latency and cursor
    send(8'h41);
    drain(200);
    chk_cur("after_A", 1, 0);
    chk("lat_we", we_cyc - rd_cyc, 1);
    chk("lat_wr", wr_cyc - rd_cyc, 2);

    // full line then wrap to next row
    do_reset();
    for (int i = 0; i < 80; i++) send(8'h61 + 8'(i % 26));
    send(8'h42);
    drain(2000);
    chk_cur("line_wrap", 1, 1);
    chk("rd_gap", min_rd_gap, 3);

    // CR on last row wraps to the top
    do_reset();
    for (int i = 0; i < 29; i++) send(8'h0D);
    drain(1000);
    chk_cur("cr29", 0, 29);
    send(8'h0D);
    drain(200);
    chk_cur("cr_wrap", 0, 0);

    // backspace across a row boundary, then at home
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h0D);
    drain(200);
    chk_cur("cr3", 0, 3);
    send(8'h08);
    drain(200);
    chk_cur("bs_row", 79, 2);
    do_reset();
    send(8'h08);
    drain(200);
    chk_cur("bs_home", 0, 0);

    // transmit stall with a second byte waiting
    do_reset();
    tx_full = 1'b1;
    send(8'h43);
    send(8'h44);
    n = 0;
    while (!vram_we && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL stall_write_timeout: got no vram_we expected one within 20 cycles");
    end
    stall = 0;
    repeat (50) begin
      @(negedge clk);
      if (wr_uart || rd_uart) stall++;
    end
    chk("stall_strobes", stall, 0);
    chk("stall_rx_pending", rx_wp - rx_rp, 1);
    tx_full = 1'b0;
    drain(200);
    chk_cur("after_stall", 2, 0);

    // discarded byte, then full clear
    do_reset();
    send(8'h5A);
    send(8'h07);
    drain(200);
    chk_cur("discard", 1, 0);
    send(8'h1B);
    drain(4000);
    chk_cur("clear", 0, 0);
    chk("clear_run", max_run, 2400);

    // reset in the middle of a clear
    send(8'h1B);
    repeat (100) @(negedge clk);
    #2;
    rst_n = 1'b0;
    flush();
    #1;
    chk_all_zero("mid_clear_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk_cur("post_rst", 0, 0);
    send(8'h41);
    drain(200);
    chk_cur("post_rst_A", 1, 0);

    chk("exp_left", (w_wp - w_rp) + (e_wp - e_rp), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_text_ctrl.md
UART_TEXT_CTRL -- requirements
Module: uart_text_ctrl

Interface
REQ-001 Parameter COLS, default 80, text columns per row.
REQ-002 Parameter ROWS, default 30, text rows.
REQ-003 Parameter ECHO, default 1, enables echo of accepted bytes to the UART transmitter.
REQ-004 Port clk, input, 1, single clock for the whole block.
REQ-005 Port rst_n, input, 1, reset: asynchronous, active-low.
REQ-006 Port rx_empty, input, 1, UART receive FIFO empty.
REQ-007 Port rd_data, input, 8, UART receive FIFO head byte, valid whenever rx_empty=0.
REQ-008 Port tx_full, input, 1, UART transmit FIFO full.
REQ-009 Port rd_uart, output, 1, one-cycle receive FIFO pop strobe.
REQ-010 Port wr_uart, output, 1, one-cycle transmit FIFO push strobe.
REQ-011 Port wr_data, output, 8, byte pushed with wr_uart.
REQ-012 Port vram_we, output, 1, text-buffer write strobe.
REQ-013 Port vram_x, output, 7, write column; vram_y, output, 5, write row; vram_din, output, 8, character code.
REQ-014 Port cur_x, output, 7, and cur_y, output, 5: cursor position, used by the VGA side for cursor display.

Function
REQ-015 FSM states: IDLE, DECODE, ECHO, CLEAR.
REQ-016 IDLE: when rx_empty=0, latch rd_data into char_reg, pulse rd_uart for one cycle, and go to DECODE; otherwise stay in IDLE.
REQ-017 Printable byte (0x20-0x7E), in DECODE:
- vram_we=1, address (cur_x,cur_y), vram_din=char_reg;
- cursor advances one column;
- at cur_x=COLS-1, column goes to 0 and row increments.
REQ-018 CR (0x0D), in DECODE: no write; cur_x=0; row increments.
REQ-019 Row increment at cur_y=ROWS-1 wraps to 0; there is no scrolling.
REQ-020 BS (0x08), in DECODE:
- cursor steps back one column; at cur_x=0, it moves to (COLS-1, cur_y-1);
- then writes 0x20 at the new position in the same cycle;
- at (0,0), BS is a no-op with no write.
REQ-021 ESC (0x1B), in DECODE: go to CLEAR. ESC is not echoed.
REQ-022 CLEAR:
- writes 0x20 to every cell, one per cycle, row-major from (0,0), COLS*ROWS cycles;
- then cursor=(0,0) and return to IDLE;
- rd_uart is held 0 throughout.
REQ-023 All other bytes are discarded: no write, no cursor change, no echo; DECODE returns to IDLE.
REQ-024 After a printable, CR or BS byte, with ECHO=1, DECODE goes to ECHO; with ECHO=0, it goes to IDLE.
REQ-025 ECHO:
- while tx_full=1, stall with wr_uart=0;
- when tx_full=0, pulse wr_uart with wr_data=char_reg and go to IDLE.
REQ-026 Latency: rd_uart at cycle T, vram_we at T+1, earliest wr_uart at T+2.
REQ-027 Maximum throughput is one byte per 3 cycles.
REQ-028 rd_uart, wr_uart and vram_we are never asserted in the same cycle.
REQ-029 Only one receive byte is in flight; no pop occurs while the block is outside IDLE.
REQ-030 All outputs are registered.

Reset
REQ-031 rst_n=0 asynchronously forces:
- FSM to IDLE;
- char_reg=0x00, cur_x=0, cur_y=0;
- rd_uart=0, wr_uart=0, vram_we=0;
- wr_data, vram_x, vram_y and vram_din to 0.
REQ-032 Reset during CLEAR or ECHO abandons the operation; no pending echo or write resumes after reset.

Structure
REQ-033 Shared package uart_text_pkg holds:
- FSM state encoding;
- character constants CH_CR, CH_BS, CH_ESC, CH_SP;
- printable range bounds.
REQ-034 Sub-module text_cursor holds cur_x/cur_y and is parameterized by COLS and ROWS.
REQ-035 text_cursor commands: advance, newline, backstep, home. Each command applies in one cycle with the wrap rules of REQ-017 to REQ-020.

Verification
REQ-036 Byte 0x41 at reset cursor -> rd_uart at T, vram_we at T+1 with (0,0,0x41), wr_uart at T+2 with 0x41, cursor (1,0).
REQ-037 80 printable bytes, then 0x42 -> 0x42 written at (0,1); cursor (1,1).
REQ-038 Cursor (0,29), then CR -> cursor (0,0), no vram_we, echo 0x0D.
REQ-039 Cursor (0,3), then BS -> write 0x20 at (79,2), cursor (79,2); BS at (0,0) -> no write, echo 0x08.
REQ-040 tx_full held high for 50 cycles during ECHO -> wr_uart=0 and rd_uart=0 throughout; single wr_uart after release.
REQ-041 ESC -> 2400 consecutive vram_we writes of 0x20 covering (0,0) to (79,29), no echo, cursor (0,0); rst_n pulsed mid-clear -> all outputs 0 immediately and FSM in IDLE.
